// File: rtl/event_timestamp_logger.sv
// ----------------------------------------------------------------------------
// event_timestamp_logger
//
// Records the timebase value at every accepted rising edge of ev_in into a
// small FIFO. A holdoff window after each accepted event suppresses further
// edges, which debounces a noisy or chattering event source.
//
// Optional feature macro: EVENT_TS_DROP_COUNT_EN
//   defined   -> drop_cnt counts events lost to a full FIFO (saturating)
//   undefined -> drop_cnt is tied to 0
//
// Ports
//   clk       in   1              single clock, rising edge
//   rst       in   1              asynchronous, active-high reset
//   ev_in     in   1              event level; a 0->1 transition is one event
//   ts_valid  out  1              FIFO head holds a timestamp
//   ts_ready  in   1              consumer takes the head when ts_valid & ts_ready
//   ts_data   out  TS_W           timestamp at FIFO head (0 while empty)
//   fifo_cnt  out  clog2(DEPTH)+1 entries held, 0..DEPTH
//   ovf       out  1              sticky: an event was lost to a full FIFO
//   ovf_clr   in   1              clears ovf (a same-cycle drop wins)
//   drop_cnt  out  16             saturating count of lost events
//
// Handshake: a transfer happens on a rising edge where ts_valid & ts_ready
// are both high. ts_valid never depends combinationally on ts_ready, and
// ts_data holds its value while ts_valid is high and ts_ready is low.
// ----------------------------------------------------------------------------
module event_timestamp_logger #(
    parameter int TS_W    = 32,
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_in,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [TS_W-1:0]          ts_data,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [15:0]              drop_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HC_W-1:0] HOLD_LOAD = (HOLDOFF > 1) ? HC_W'(HOLDOFF - 1) : '0;
    localparam logic [AW:0]     FULL_CNT  = (AW + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [TS_W-1:0] tb_q, tb_d;
    logic            ev_q;
    logic            arm_q;
    logic [0:0]      state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic [AW-1:0]   wp_q, rp_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ovf_q;
    logic [TS_W-1:0] mem [DEPTH];

    logic rise, accept, full, push, drop, pop;

    // arm_q is low for the first cycle after reset, so a level already high
    // across reset release is absorbed into ev_q instead of becoming an event.
    assign rise   = ev_in & ~ev_q & arm_q;
    assign accept = rise & (state_q == ST_IDLE);
    // Full is judged on the registered count, before any same-cycle pop.
    assign full   = (cnt_q == FULL_CNT);
    assign push   = accept & ~full;
    assign drop   = accept & full;
    assign pop    = ts_valid & ts_ready;

    assign tb_d = tb_q + 1'b1;

    // Holdoff: the counter is loaded with HOLDOFF-1 and the FSM returns to
    // IDLE in the cycle the counter reaches 0, so a rise exactly HOLDOFF
    // cycles after the accepted one is taken again.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (HOLDOFF > 0)) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end
                if (hold_q <= HC_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_q    <= '0;
            ev_q    <= 1'b0;
            arm_q   <= 1'b0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            tb_q    <= tb_d;
            ev_q    <= ev_in;
            arm_q   <= 1'b1;
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage carries no reset; the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= tb_q;
    end

    assign ts_valid = (cnt_q != '0);
    assign ts_data  = ts_valid ? mem[rp_q] : '0;
    assign fifo_cnt = cnt_q;
    assign ovf      = ovf_q;

`ifdef EVENT_TS_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_event_timestamp_logger.sv
// ----------------------------------------------------------------------------
// tb_event_timestamp_logger
//
// Three instances share one stimulus stream:
//   u_a : TS_W=32, DEPTH=8, HOLDOFF=10
//   u_b : TS_W=32, DEPTH=8, HOLDOFF=0
//   u_c : TS_W=8,  DEPTH=8, HOLDOFF=0   (timebase wrap)
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// "Cycle k" is the k-th clock period after reset release, in which the
// timebase reads k.
// ----------------------------------------------------------------------------
module tb_event_timestamp_logger;

`ifdef EVENT_TS_DROP_COUNT_EN
    localparam int DU = 1;
`else
    localparam int DU = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ev_in = 1'b0;
    logic ts_ready = 1'b0;
    logic ovf_clr = 1'b0;

    logic        a_valid, b_valid, c_valid;
    logic [31:0] a_data, b_data;
    logic [7:0]  c_data;
    logic [3:0]  a_cnt, b_cnt, c_cnt;
    logic        a_ovf, b_ovf, c_ovf;
    logic [15:0] a_drop, b_drop, c_drop;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    event_timestamp_logger #(.TS_W(32), .DEPTH(8), .HOLDOFF(10)) u_a (
        .clk(clk), .rst(rst), .ev_in(ev_in), .ts_valid(a_valid), .ts_ready(ts_ready),
        .ts_data(a_data), .fifo_cnt(a_cnt), .ovf(a_ovf), .ovf_clr(ovf_clr), .drop_cnt(a_drop)
    );

    event_timestamp_logger #(.TS_W(32), .DEPTH(8), .HOLDOFF(0)) u_b (
        .clk(clk), .rst(rst), .ev_in(ev_in), .ts_valid(b_valid), .ts_ready(ts_ready),
        .ts_data(b_data), .fifo_cnt(b_cnt), .ovf(b_ovf), .ovf_clr(ovf_clr), .drop_cnt(b_drop)
    );

    event_timestamp_logger #(.TS_W(8), .DEPTH(8), .HOLDOFF(0)) u_c (
        .clk(clk), .rst(rst), .ev_in(ev_in), .ts_valid(c_valid), .ts_ready(ts_ready),
        .ts_data(c_data), .fifo_cnt(c_cnt), .ovf(c_ovf), .ovf_clr(ovf_clr), .drop_cnt(c_drop)
    );

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic go_to(input int k);
        while (cyc < k) next_cycle();
    endtask

    task automatic pulse(input int k);
        go_to(k);
        ev_in = 1'b1;
        next_cycle();
        ev_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ev_in = 1'b0;
        ts_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ev_in = 1'b0;
        ts_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d, expected 0", a_valid); end
        n_cmp++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, expected 0", a_cnt); end
        n_cmp++; if (a_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0d, expected 0", a_data); end
        n_cmp++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0d, expected 0", b_ovf); end
        n_cmp++; if (b_drop !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d, expected 0", b_drop); end
        n_cmp++; if (c_data !== 8'd0) begin n_fail++; $display("FAIL reset_c_data: got %0d, expected 0", c_data); end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_single_event();
        do_reset();
        ts_ready = 1'b1;
        go_to(100);
        ev_in = 1'b1;
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid: got %0d, expected 0", a_valid); end
        next_cycle();
        ev_in = 1'b0;
        n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0d, expected 1", a_valid); end
        n_cmp++; if (a_data !== 32'd100) begin n_fail++; $display("FAIL single_data: got %0d, expected 100", a_data); end
        n_cmp++; if (a_cnt !== 4'd1) begin n_fail++; $display("FAIL single_cnt: got %0d, expected 1", a_cnt); end
        next_cycle();
        n_cmp++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL single_popped: got %0d, expected 0", a_cnt); end
        ts_ready = 1'b0;
    endtask

    task automatic test_holdoff();
        do_reset();
        pulse(200);
        pulse(205);
        n_cmp++; if (a_cnt !== 4'd1) begin n_fail++; $display("FAIL holdoff_ignored: got %0d, expected 1", a_cnt); end
        pulse(210);
        n_cmp++; if (a_cnt !== 4'd2) begin n_fail++; $display("FAIL holdoff_cnt: got %0d, expected 2", a_cnt); end
        n_cmp++; if (a_data !== 32'd200) begin n_fail++; $display("FAIL holdoff_first: got %0d, expected 200", a_data); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL holdoff_ovf: got %0d, expected 0", a_ovf); end
        ts_ready = 1'b1;
        next_cycle();
        n_cmp++; if (a_data !== 32'd210) begin n_fail++; $display("FAIL holdoff_second: got %0d, expected 210", a_data); end
        next_cycle();
        n_cmp++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL holdoff_drained: got %0d, expected 0", a_cnt); end
        ts_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) pulse(10 + 2 * i);
        go_to(30);
        n_cmp++; if (b_cnt !== 4'd8) begin n_fail++; $display("FAIL ovf_cnt: got %0d, expected 8", b_cnt); end
        n_cmp++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0d, expected 1", b_ovf); end
        n_cmp++; if (b_drop !== 16'(2 * DU)) begin n_fail++; $display("FAIL ovf_drop: got %0d, expected %0d", b_drop, 2 * DU); end
        n_cmp++; if (a_cnt !== 4'd2) begin n_fail++; $display("FAIL ovf_holdoff_cnt: got %0d, expected 2", a_cnt); end
        n_cmp++; if (b_data !== 32'd10) begin n_fail++; $display("FAIL ovf_stable_head: got %0d, expected 10", b_data); end
        ts_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %0d, expected 1", i, b_valid); end
            n_cmp++; if (b_data !== 32'(10 + 2 * i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0d, expected %0d", i, b_data, 10 + 2 * i); end
            next_cycle();
        end
        ts_ready = 1'b0;
        n_cmp++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %0d, expected 0", b_valid); end
        n_cmp++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL drain_ovf_sticky: got %0d, expected 1", b_ovf); end
    endtask

    task automatic test_full_pop_drop();
        do_reset();
        for (int i = 0; i < 8; i++) pulse(10 + 2 * i);
        go_to(26);
        n_cmp++; if (b_cnt !== 4'd8) begin n_fail++; $display("FAIL full_cnt: got %0d, expected 8", b_cnt); end
        n_cmp++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL full_ovf_pre: got %0d, expected 0", b_ovf); end
        ev_in = 1'b1;
        ts_ready = 1'b1;
        ovf_clr = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        ts_ready = 1'b0;
        ovf_clr = 1'b0;
        n_cmp++; if (b_cnt !== 4'd7) begin n_fail++; $display("FAIL full_pop_cnt: got %0d, expected 7", b_cnt); end
        n_cmp++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL full_set_wins: got %0d, expected 1", b_ovf); end
        n_cmp++; if (b_data !== 32'd12) begin n_fail++; $display("FAIL full_head: got %0d, expected 12", b_data); end
        n_cmp++; if (b_drop !== 16'(DU)) begin n_fail++; $display("FAIL full_drop: got %0d, expected %0d", b_drop, DU); end
        ovf_clr = 1'b1;
        next_cycle();
        ovf_clr = 1'b0;
        n_cmp++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0d, expected 0", b_ovf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(10);
        go_to(12);
        ev_in = 1'b1;
        ts_ready = 1'b1;
        next_cycle();
        ev_in = 1'b0;
        ts_ready = 1'b0;
        n_cmp++; if (b_cnt !== 4'd1) begin n_fail++; $display("FAIL b2b_cnt: got %0d, expected 1", b_cnt); end
        n_cmp++; if (b_data !== 32'd12) begin n_fail++; $display("FAIL b2b_data: got %0d, expected 12", b_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse(255);
        pulse(257);
        go_to(258);
        n_cmp++; if (c_cnt !== 4'd2) begin n_fail++; $display("FAIL wrap_cnt: got %0d, expected 2", c_cnt); end
        n_cmp++; if (c_data !== 8'd255) begin n_fail++; $display("FAIL wrap_first: got %0d, expected 255", c_data); end
        ts_ready = 1'b1;
        next_cycle();
        ts_ready = 1'b0;
        n_cmp++; if (c_data !== 8'd1) begin n_fail++; $display("FAIL wrap_second: got %0d, expected 1", c_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) pulse(10 + 2 * i);
        pulse(30);
        go_to(32);
        n_cmp++; if (a_cnt !== 4'd3) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d, expected 3", a_cnt); end
        n_cmp++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf: got %0d, expected 1", b_ovf); end
        rst = 1'b1;
        ev_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0d, expected 0", a_valid); end
        n_cmp++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d, expected 0", a_cnt); end
        n_cmp++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %0d, expected 0", b_ovf); end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        go_to(6);
        n_cmp++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL release_a: got %0d, expected 0", a_cnt); end
        n_cmp++; if (b_cnt !== 4'd0) begin n_fail++; $display("FAIL release_b: got %0d, expected 0", b_cnt); end
        ev_in = 1'b0;
        pulse(10);
        n_cmp++; if (a_data !== 32'd10) begin n_fail++; $display("FAIL post_reset_event: got %0d, expected 10", a_data); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_event();
        test_holdoff();
        test_overflow();
        test_full_pop_drop();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/event_timestamp_logger.md
EVENT_TIMESTAMP_LOGGER -- requirements
Module: event_timestamp_logger

Interface
REQ-001 Parameters SHALL be, one per line:
  TS_W, 32, timestamp and timebase width in bits (8..64).
  DEPTH, 8, timestamp FIFO entries (power of 2, 2..64).
  HOLDOFF, 10, cycles after an accepted event during which new rising edges are ignored (0 = no holdoff).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  asynchronous, active-high reset.
  ev_in  in  1  event input, level; a 0->1 transition is one event.
  ts_valid  out  1  FIFO head holds a timestamp.
  ts_ready  in  1  consumer accepts head when ts_valid & ts_ready.
  ts_data  out  TS_W  timestamp at FIFO head.
  fifo_cnt  out  clog2(DEPTH)+1  entries held.
  ovf  out  1  sticky: at least one event lost to FIFO full.
  ovf_clr  in  1  clears ovf.
  drop_cnt  out  16  saturating count of events lost to FIFO full (see Configuration).

Function
REQ-003 Timebase: free-running TS_W counter; +1 every cycle; wraps from all-ones to 0.
REQ-004 ev_in SHALL be registered once (ev_q); rise = ev_in & ~ev_q, detected in the cycle ev_in is first sampled high.
REQ-005 Timestamp of an event = timebase value in the cycle rise is detected.
REQ-006 Holdoff FSM, two states: IDLE, HOLD.
  IDLE + rise -> event accepted; if HOLDOFF>0 go HOLD, load hold counter with HOLDOFF-1.
  HOLD: rises ignored (not pushed, not counted as drops); counter decrements each cycle; at 0 -> IDLE.
  HOLDOFF=0: FSM stays IDLE; every rise accepted.
REQ-007 Accepted event is written to the FIFO at the end of the detect cycle; ts_valid rises the next cycle when the FIFO was empty (1-cycle latency).
REQ-008 FIFO full is evaluated before any same-cycle pop: accepted event with fifo_cnt==DEPTH is dropped, ovf set, drop_cnt incremented; FSM still enters HOLD.
REQ-009 Push and pop in the same cycle (not full): both occur; fifo_cnt unchanged; order preserved.
REQ-010 Pop only when ts_valid & ts_ready; ts_ready while empty has no effect.
REQ-011 ts_data SHALL be stable while ts_valid & ~ts_ready.
REQ-012 Drop and ovf_clr in the same cycle: ovf ends set (set wins).
REQ-013 Read/write pointers wrap modulo DEPTH; fifo_cnt ranges 0..DEPTH.

Reset
REQ-014 While rst is high: timebase=0, ev_q=0, FSM=IDLE, hold counter=0, FIFO empty, ts_valid=0, fifo_cnt=0, ts_data=0, ovf=0, drop_cnt=0.
REQ-015 Reset mid-operation discards all FIFO contents and pending holdoff; ev_in held high across reset deassertion SHALL NOT produce an event (ev_q reset to 0, but rise gated for the first cycle after reset).

Configuration
REQ-016 Macro EVENT_TS_DROP_COUNT_EN defined: drop_cnt counts dropped events, saturating at 16'hFFFF; cleared only by reset.
REQ-017 Macro undefined: drop_cnt tied to 0, counter logic absent; ovf behaviour unchanged.

Verification
REQ-018 HOLDOFF=10, ts_ready=1: pulse ev_in at cycle 100 -> one entry, ts_data=100, ts_valid high at cycle 101.
REQ-019 HOLDOFF=10: rises at cycles 200 and 205 -> one entry (200); rise at 210 -> second entry (210); mirrors request-ignored-while-pending behaviour.
REQ-020 HOLDOFF=0, DEPTH=8, ts_ready=0: 10 rises -> fifo_cnt=8, ovf=1, drop_cnt=2 (macro on) or 0 (macro off); then drain -> 8 timestamps in order, strictly increasing.
REQ-021 FIFO full with ts_ready=1 and rise in the same cycle -> event dropped, fifo_cnt=7 next cycle; ovf_clr same cycle -> ovf=1.
REQ-022 TS_W=8: event at timebase 255 then 2 cycles later (HOLDOFF=0) -> entries 255 then 1.
REQ-023 Assert rst while FIFO holds 3 entries and FSM in HOLD -> next cycle ts_valid=0, fifo_cnt=0, ovf=0; ev_in held high through release -> no entry.
